// File: rtl/protocol_frame_sequencer.sv
`timescale 1ns/1ps
// protocol_frame_sequencer: frames the decoded LED-chain bit stream into words, claims the
// first flagged word of each frame for the local LED and forwards every bit downstream.
module protocol_frame_sequencer #(
    parameter int WORD_BITS  = 32,
    parameter int GAP_CYCLES = 255,
    parameter int GAP_W      = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_data,
    input  logic                 in_clk,
    input  logic                 in_sync,
    output logic                 out_data,
    output logic                 out_clk,
    output logic [WORD_BITS-3:0] led_word,
    output logic                 led_valid,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 busy
);
    localparam int CNT_W = $clog2(WORD_BITS);
    localparam int PAY_W = WORD_BITS - 2;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORD_BITS - 1);
    localparam logic [GAP_W-1:0] GAP_MAX  = GAP_W'(GAP_CYCLES);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, HUNT, CAPTURE, PASS, ERROR} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
    logic [PAY_W-1:0] shift_q, shift_d;
    logic [PAY_W-1:0] led_word_q, led_word_d;
    logic             xor_q, xor_d;
    logic             led_valid_q, led_valid_d;
    logic             parity_err_q, parity_err_d;
    logic             frame_err_q, frame_err_d;
    logic             out_data_q, out_data_d;
    logic             out_clk_q, out_clk_d;
    logic             accept, timeout, swap;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path leaves a latch behind.
        accept       = in_clk & in_sync;
        // A strobe in the cycle the gap would expire wins, so the frame survives it.
        timeout      = (state_q != IDLE) && !accept && (gap_cnt_q >= GAP_LAST);
        swap         = 1'b0;
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        xor_d        = xor_q;
        led_word_d   = led_word_q;
        led_valid_d  = 1'b0;
        parity_err_d = 1'b0;
        frame_err_d  = frame_err_q;

        if (accept)
            gap_cnt_d = '0;
        else if (gap_cnt_q == GAP_MAX)
            gap_cnt_d = GAP_MAX;
        else
            gap_cnt_d = gap_cnt_q + 1'b1;

        if (accept)
            bit_cnt_d = (bit_cnt_q == LAST_BIT) ? '0 : bit_cnt_q + 1'b1;

        if (state_q != IDLE && state_q != ERROR && !in_sync) begin
            state_d     = ERROR;
            frame_err_d = 1'b1;
        end else if (timeout) begin
            state_d   = IDLE;
            bit_cnt_d = '0;
            if (bit_cnt_q != '0)
                frame_err_d = 1'b1;
        end else if (accept) begin
            unique case (state_q)
                IDLE, HUNT: begin
                    if (state_q == IDLE)
                        frame_err_d = 1'b0;
                    if (bit_cnt_q == '0) begin
                        if (in_data) begin
                            swap    = 1'b1;
                            state_d = CAPTURE;
                            shift_d = '0;
                            xor_d   = 1'b0;
                        end else begin
                            state_d = HUNT;
                        end
                    end
                end
                CAPTURE: begin
                    if (bit_cnt_q == LAST_BIT) begin
                        if (xor_q == in_data) begin
                            led_word_d  = shift_q;
                            led_valid_d = 1'b1;
                        end else begin
                            parity_err_d = 1'b1;
                        end
                        state_d = PASS;
                    end else begin
                        shift_d = {shift_q[PAY_W-2:0], in_data};
                        xor_d   = xor_q ^ in_data;
                    end
                end
                default: ;
            endcase
        end

        out_clk_d  = accept & (state_q != ERROR);
        out_data_d = in_data ^ swap;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            bit_cnt_q    <= '0;
            gap_cnt_q    <= '0;
            shift_q      <= '0;
            xor_q        <= 1'b0;
            led_word_q   <= '0;
            led_valid_q  <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            out_data_q   <= 1'b0;
            out_clk_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge values.
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            gap_cnt_q    <= gap_cnt_d;
            shift_q      <= shift_d;
            xor_q        <= xor_d;
            led_word_q   <= led_word_d;
            led_valid_q  <= led_valid_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
            out_data_q   <= out_data_d;
            out_clk_q    <= out_clk_d;
        end
    end

    assign out_data   = out_data_q;
    assign out_clk    = out_clk_q;
    assign led_word   = led_word_q;
    assign led_valid  = led_valid_q;
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_protocol_frame_sequencer.sv
`timescale 1ns/1ps
// Bench for protocol_frame_sequencer: a word-level model predicts forwarded bits and LED
// events into queues; a falling-edge monitor pops and compares whatever the DUT presents.
module tb_protocol_frame_sequencer;
    localparam int WB  = 32;
    localparam int PW  = WB - 2;
    localparam int GAP = 255;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_data = 1'b0;
    logic          in_clk = 1'b0;
    logic          in_sync = 1'b1;
    logic          out_data, out_clk, led_valid, parity_err, frame_err, busy;
    logic [PW-1:0] led_word;

    typedef struct {
        bit            good;
        logic [PW-1:0] led;
    } evt_t;

    bit            exp_fwd[$];
    evt_t          exp_evt[$];
    int            vectors = 0;
    int            miscompares = 0;
    bit            m_claimed = 1'b0;
    bit            m_err = 1'b0;
    int            m_bits = 0;
    logic [PW-1:0] m_last_good = '0;

    always #5 clk = ~clk;

    protocol_frame_sequencer #(.WORD_BITS(WB), .GAP_CYCLES(GAP), .GAP_W(8)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_clk(in_clk), .in_sync(in_sync),
        .out_data(out_data), .out_clk(out_clk), .led_word(led_word), .led_valid(led_valid),
        .parity_err(parity_err), .frame_err(frame_err), .busy(busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        in_clk = 1'b0;
        repeat (n) tick();
    endtask

    task automatic strobe(input logic b);
        in_data = b;
        in_clk  = 1'b1;
        tick();
        in_clk  = 1'b0;
        in_data = 1'($urandom_range(0, 1));
    endtask

    // Word as sent on the wire: flag, led payload MSB first, then parity over the payload.
    function automatic logic [WB-1:0] build_word(input logic flag, input logic [PW-1:0] led,
                                                 input bit good);
        logic [WB-1:0] w;
        w[0] = flag;
        for (int i = 0; i < PW; i++) w[1+i] = led[PW-1-i];
        w[WB-1] = (^led) ^ !good;
        return w;
    endfunction

    // Sends bits 0..nbits-1; gap_len idle cycles replace the normal spacing before bit gap_at.
    task automatic send_word(input logic [WB-1:0] w, input int nbits, input int sp,
                             input int gap_at, input int gap_len);
        bit            claim_now;
        logic [PW-1:0] led;
        evt_t          e;
        claim_now = !m_claimed && w[0];
        if (claim_now) begin
            m_claimed = 1'b1;
            if (nbits == WB) begin
                for (int i = 0; i < PW; i++) led[PW-1-i] = w[1+i];
                e.good = ((^led) == w[WB-1]);
                e.led  = e.good ? led : m_last_good;
                if (e.good) m_last_good = led;
                exp_evt.push_back(e);
            end
        end
        for (int i = 0; i < nbits; i++) begin
            if (i > 0) idle((i == gap_at) ? gap_len : sp - 1);
            exp_fwd.push_back(w[i] ^ (claim_now && i == 0));
            strobe(w[i]);
        end
        m_bits += nbits;
    endtask

    task automatic end_frame();
        idle(GAP - 1);
        check("gap_hold_busy", busy, 1);
        idle(1);
        check("gap_end_busy", busy, 0);
        check("frame_err_at_end", frame_err, (m_err || (m_bits % WB != 0)) ? 1 : 0);
        m_claimed = 1'b0;
        m_bits    = 0;
        m_err     = 1'b0;
        idle(3);
    endtask

    task automatic random_frame();
        int nw;
        int sp;
        nw = $urandom_range(1, 4);
        sp = $urandom_range(1, 4);
        for (int k = 0; k < nw; k++) begin
            if (k > 0) idle(sp - 1);
            send_word(build_word(1'($urandom_range(0, 1)), PW'($urandom),
                                 $urandom_range(0, 3) != 0), WB, sp, -1, 0);
        end
        end_frame();
    endtask

    initial begin : monitor
        bit   b;
        evt_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (out_clk) begin
                    if (exp_fwd.size() == 0) begin
                        check("fwd_unexpected_out_clk", out_clk, 0);
                    end else begin
                        b = exp_fwd.pop_front();
                        check("fwd_out_data", out_data, b);
                    end
                end
                if (led_valid) begin
                    if (exp_evt.size() == 0) begin
                        check("evt_unexpected_led_valid", led_valid, 0);
                    end else begin
                        e = exp_evt.pop_front();
                        check("evt_is_good", e.good, 1);
                        check("led_word_on_valid", led_word, e.led);
                    end
                end
                if (parity_err) begin
                    if (exp_evt.size() == 0) begin
                        check("evt_unexpected_parity_err", parity_err, 0);
                    end else begin
                        e = exp_evt.pop_front();
                        check("evt_is_parity_err", e.good, 0);
                        check("led_word_on_parity_err", led_word, e.led);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #3_000_000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        logic [PW-1:0] pay;

        // Reset, then a long quiet stretch.
        repeat (3) tick();
        check("reset_outputs", {out_clk, out_data, led_valid, parity_err, frame_err, busy}, 0);
        check("reset_led_word", led_word, 0);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            idle(100);
            check("idle_flags", {out_clk, led_valid, parity_err, frame_err, busy}, 0);
        end
        check("idle_led_word", led_word, 0);

        // Single node claims word0; later flagged words pass unchanged.
        send_word(build_word(1'b1, 30'h2AAAAAAA, 1'b1), WB, 4, -1, 0);
        idle(3);
        send_word(build_word(1'b1, PW'($urandom), 1'b1), WB, 4, -1, 0);
        idle(3);
        send_word(build_word(1'b1, PW'($urandom), 1'b1), WB, 4, -1, 0);
        end_frame();
        check("single_claim_led_word", led_word, 30'h2AAAAAAA);

        // Chain pass-through: word0 belongs upstream, word1 is ours.
        send_word(build_word(1'b0, PW'($urandom), 1'b1), WB, 2, -1, 0);
        idle(1);
        send_word(build_word(1'b1, PW'($urandom), 1'b1), WB, 2, -1, 0);
        idle(1);
        send_word(build_word(1'b1, PW'($urandom), 1'b0), WB, 2, -1, 0);
        end_frame();

        // Parity fault on the claimed word; led_word must hold.
        send_word(build_word(1'b1, PW'($urandom), 1'b0), WB, 3, -1, 0);
        idle(2);
        send_word(build_word(1'b1, PW'($urandom), 1'b1), WB, 3, -1, 0);
        end_frame();
        check("parity_fault_led_word_held", led_word, m_last_good);

        // Sync loss at bit 10 of word1.
        send_word(build_word(1'b0, PW'($urandom), 1'b1), WB, 4, -1, 0);
        idle(3);
        send_word(build_word(1'b1, PW'($urandom), 1'b1), 10, 4, -1, 0);
        idle(2);
        in_sync = 1'b0;
        tick();
        check("sync_loss_frame_err", frame_err, 1);
        check("sync_loss_busy", busy, 1);
        for (int i = 0; i < 5; i++) begin
            strobe(1'($urandom_range(0, 1)));
            idle(2);
        end
        idle(GAP + 5);
        check("sync_loss_timeout_busy", busy, 0);
        check("sync_loss_frame_err_sticky", frame_err, 1);
        in_sync = 1'b1;
        idle(2);
        m_claimed = 1'b0;
        m_bits    = 0;
        m_err     = 1'b0;
        send_word(build_word(1'b1, PW'($urandom), 1'b1), WB, 2, -1, 0);
        check("frame_start_clears_frame_err", frame_err, 0);
        end_frame();

        // Gap of GAP-1 idle cycles mid-word: the word continues and is captured.
        send_word(build_word(1'b1, PW'($urandom), 1'b1), WB, 2, 12, GAP - 1);
        end_frame();

        // Gap expiring at bit_cnt=5 of a claimed word: frame error, no led_valid.
        pay = PW'($urandom);
        send_word(build_word(1'b1, pay, 1'b1), 5, 3, -1, 0);
        end_frame();
        check("partial_capture_led_word_held", led_word, m_last_good);

        // Randomised frames.
        for (int f = 0; f < 8; f++) random_frame();

        // Reset in the middle of a claimed word.
        send_word(build_word(1'b1, PW'($urandom), 1'b1), 12, 2, -1, 0);
        #1;
        exp_fwd.delete();
        exp_evt.delete();
        rst = 1'b1;
        #1;
        check("async_reset_out_clk", out_clk, 0);
        check("async_reset_busy", busy, 0);
        check("async_reset_led_word", led_word, 0);
        tick();
        tick();
        rst = 1'b0;
        m_claimed   = 1'b0;
        m_bits      = 0;
        m_err       = 1'b0;
        m_last_good = '0;
        idle(4);
        random_frame();

        idle(10);
        check("fwd_queue_drained", exp_fwd.size(), 0);
        check("evt_queue_drained", exp_evt.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/protocol_frame_sequencer.md
Name: protocol_frame_sequencer

Overview:
- Controls the forwarding datapath of one smart-LED node in the daisy chain.
- Consumes the decoded bit stream (data, bit strobe, sync) from the Manchester decoder.
- Frames the stream into fixed-length words and claims the first unclaimed word for the local LED.
- Forwards every bit downstream, inverting the claim flag of the claimed word; downstream goes to the Manchester encoder, the local word goes to the PWM block.

Parameters:
- WORD_BITS, 32: bits per word. Bit 0 is the claim flag, bits 1..WORD_BITS-2 are payload, bit WORD_BITS-1 is parity.
- GAP_CYCLES, 255: number of clk cycles without in_clk that ends a frame.
- GAP_W, 8: width of the gap counter; must hold GAP_CYCLES.

Ports:
- clk  in  1  global clock
- rst  in  1  asynchronous, active-high reset
- in_data  in  1  decoded bit value, valid when in_clk=1
- in_clk  in  1  one-cycle strobe per received bit
- in_sync  in  1  decoder locked
- out_data  out  1  forwarded bit to the encoder
- out_clk  out  1  forwarded bit strobe
- led_word  out  WORD_BITS-2  captured payload; holds its value between updates
- led_valid  out  1  one-cycle pulse: led_word updated with good parity
- parity_err  out  1  one-cycle pulse: claimed word failed parity
- frame_err  out  1  sticky; cleared at the next frame start
- busy  out  1  high when state is not IDLE

Behaviour:
- Reset (rst=1, asynchronous): all outputs 0, led_word=0, state IDLE, bit_cnt=0, gap_cnt=0, shift register 0.
- All logic runs on posedge clk. A strobe is accepted only when in_clk=1 and in_sync=1.
- Forwarding latency is 1 cycle:
  - out_clk <= in_clk & in_sync & (state != ERROR)
  - out_data <= in_data ^ swap
  - swap=1 only for bit 0 of the word being claimed.
  - With in_sync=0 nothing is forwarded.
- bit_cnt increments on each accepted strobe and wraps WORD_BITS-1 -> 0.
- gap_cnt: cleared on each accepted strobe, otherwise increments, saturating at GAP_CYCLES.
- States and transitions:
  - IDLE: the first accepted strobe starts a frame. Clear frame_err; bit_cnt processing applies to that strobe, which is treated as bit 0 under the HUNT rules.
  - HUNT: at bit_cnt=0, in_data=1 means claim the word: swap=1, go to CAPTURE. in_data=0 means forward unchanged and stay in HUNT.
  - CAPTURE: shift bits 1..WORD_BITS-2 into the payload register MSB-first and keep a running XOR.
    - At bit WORD_BITS-1, parity is good when running XOR == in_data.
    - Good parity: led_word <= payload, led_valid pulse on the following cycle.
    - Bad parity: parity_err pulse; led_word unchanged.
    - Go to PASS in both cases.
  - PASS: forward all later words unchanged, whatever their claim flag. Only one claim per frame.
  - ERROR: forwarding suppressed.
- End of frame: gap_cnt reaching GAP_CYCLES in any non-IDLE state returns to IDLE.
  - If bit_cnt != 0 at that point (partial word), set frame_err.
  - A partial CAPTURE produces no led_valid.
- in_sync falling while busy: go to ERROR and set frame_err. ERROR exits to IDLE only via the gap timeout, and gap_cnt keeps counting while in_sync=0.
- Simultaneous events:
  - A strobe in the same cycle the gap reaches GAP_CYCLES: the strobe wins, gap_cnt clears, no frame end.
  - in_sync falling in the same cycle as in_clk: the strobe is ignored and ERROR is entered.
- Asserting rst mid-word aborts immediately. No led_valid is emitted, and out_clk drops asynchronously.

Test Plan:
- Reset then idle: rst pulsed, no strobes -> all outputs 0, busy=0 for 1000 cycles.
- Single-node claim: frame of 3 words, each bit strobed every 4 cycles. Word0 = flag 1, payload 30'h2AAAAAAA, correct parity; words 1 and 2 flag 1.
  - -> led_word=30'h2AAAAAAA, exactly one led_valid pulse.
  - -> out_data equals input with only word0 bit0 inverted, delayed 1 cycle.
- Chain pass-through: word0 flag 0, word1 flag 1 -> word1 claimed, word0 forwarded unmodified.
- Parity fault: claimed word with the parity bit flipped -> one parity_err pulse, led_valid=0, led_word keeps its previous value, later words forwarded.
- Sync loss: in_sync dropped at bit 10 of word1 -> frame_err=1, out_clk stays 0; after GAP_CYCLES idle, busy=0. Next frame start clears frame_err.
- Gap boundaries:
  - Strobe gap of GAP_CYCLES-1 mid-word -> frame continues.
  - Gap of GAP_CYCLES at bit_cnt=5 -> IDLE with frame_err=1.
  - Gap at bit_cnt=0 -> IDLE with frame_err=0.
